// File: rtl/regfile_scan_pkg.sv
// regfile_scan_pkg
//   Shared definitions for the register-file scanner:
//   - SLOT_W      : width of the slot index (room for 16 registers plus PC)
//   - DISP_BLANK  : idle word shown on the display, {32'h88888888, valid=0}
//   - ST_*        : 3-bit FSM state encodings and the scan_state_t enum built on them
package regfile_scan_pkg;

    localparam int SLOT_W = 5;

    localparam logic [32:0] DISP_BLANK = {32'h88888888, 1'b0};

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ADDR    = ST_ADDR,
        WAIT    = ST_WAIT,
        CAPTURE = ST_CAPTURE,
        HOLD    = ST_HOLD
    } scan_state_t;

endpackage

// File: rtl/rise_detect.sv
// rise_detect
//   Rising-edge detector for a debounced button level. One history flop;
//   a level held high produces a single one-cycle rise.
// Ports
//   clk    in   system clock
//   Rst_n  in   synchronous active-low reset (clears history to 0)
//   sig    in   level input
//   rise   out  sig & ~sig_q
module rise_detect (
    input  logic clk,
    input  logic Rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/regfile_scanner.sv
// regfile_scanner
//   Dumps the register file to the 7-segment display. Sweeps R_Addr over the
//   general registers, waits READ_LAT cycles for the read data, latches it into
//   the 33-bit {value, valid} display word, then holds it for DWELL_CYCLES
//   (auto_mode=1) or until the next step button press (auto_mode=0).
//
//   Optional feature macro: SCAN_PC_EN
//     defined   -> one extra slot (index NUM_REGS) shows R_Data_PC; R_Addr is
//                  left at its previous value for that slot.
//     undefined -> scan ends at slot NUM_REGS-1; R_Data_PC is ignored.
//
// Ports
//   clk        in   system clock
//   Rst_n      in   synchronous active-low reset; aborts a running scan
//   start      in   button level; rising edge starts a scan when idle
//   step       in   button level; rising edge advances a slot in manual mode
//   auto_mode  in   1 = dwell-timer advance, 0 = step advance
//   mode_in    in   processor mode, latched onto M at scan start
//   R_Addr     out  register file read address
//   M          out  mode presented to the register file
//   R_Data     in   read data for R_Addr
//   R_Data_PC  in   PC value
//   data       out  {value[32:1], valid}
//   slot       out  index of the slot being scanned / shown
//   busy       out  high while a scan is running
//   done       out  one-cycle pulse when the final slot is released
//
// FSM
//   state   | meaning
//   IDLE    | waiting for start rise, display keeps last word
//   ADDR    | drive R_Addr for the current slot, load latency counter
//   WAIT    | count down READ_LAT cycles of register-file read latency
//   CAPTURE | latch read data into the display word, clear dwell
//   HOLD    | show the word until dwell expires or step rises
module regfile_scanner
    import regfile_scan_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int READ_LAT     = 1,
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              start,
    input  logic              step,
    input  logic              auto_mode,
    input  logic [4:0]        mode_in,
    output logic [3:0]        R_Addr,
    output logic [4:0]        M,
    input  logic [31:0]       R_Data,
    input  logic [31:0]       R_Data_PC,
    output logic [32:0]       data,
    output logic [SLOT_W-1:0] slot,
    output logic              busy,
    output logic              done
);

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int LAT_W   = $clog2(READ_LAT + 1);

    localparam logic [SLOT_W-1:0]  PC_SLOT    = SLOT_W'(NUM_REGS);
`ifdef SCAN_PC_EN
    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(NUM_REGS);
`else
    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(NUM_REGS - 1);
`endif
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [LAT_W-1:0]   LAT_INIT   = LAT_W'(READ_LAT);
    localparam logic [LAT_W-1:0]   LAT_ONE    = LAT_W'(1);

    scan_state_t        state;
    logic [DWELL_W-1:0] dwell;
    logic [LAT_W-1:0]   lat_cnt;
    logic               auto_q;
    logic               start_rise;
    logic               step_rise;
    logic               advance;
    logic [31:0]        cap_value;

    rise_detect u_start_rise (
        .clk   (clk),
        .Rst_n (Rst_n),
        .sig   (start),
        .rise  (start_rise)
    );

    rise_detect u_step_rise (
        .clk   (clk),
        .Rst_n (Rst_n),
        .sig   (step),
        .rise  (step_rise)
    );

`ifdef SCAN_PC_EN
    assign cap_value = (slot == PC_SLOT) ? R_Data_PC : R_Data;
`else
    logic unused_pc;
    assign unused_pc = ^R_Data_PC;
    assign cap_value = R_Data;
`endif

    // A change of auto_mode costs one HOLD cycle: dwell restarts and no
    // advance is taken until the new mode has been seen for a full cycle.
    always_comb begin
        advance = 1'b0;
        if (state == HOLD && auto_mode == auto_q) begin
            advance = auto_mode ? (dwell == DWELL_LAST) : step_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state   <= IDLE;
            R_Addr  <= '0;
            M       <= '0;
            slot    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            data    <= DISP_BLANK;
            dwell   <= '0;
            lat_cnt <= '0;
            auto_q  <= 1'b0;
        end else begin
            done   <= 1'b0;
            auto_q <= auto_mode;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        slot  <= '0;
                        M     <= mode_in;
                        busy  <= 1'b1;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (slot != PC_SLOT) begin
                        R_Addr <= slot[3:0];
                    end
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_ONE) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    data  <= {cap_value, 1'b1};
                    dwell <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    if (auto_mode != auto_q || !auto_mode) begin
                        dwell <= '0;
                    end else if (!advance) begin
                        dwell <= dwell + 1'b1;
                    end
                    if (advance) begin
                        if (slot == LAST_SLOT) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            slot  <= slot + 1'b1;
                            state <= ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
